// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
    input  logic CLKIN,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: oversampled start/data/stop sampling feeding a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 sample_enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 3;

    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 good_stop_c;
    logic                 bad_stop_c;

    uart_sync2 u_sync (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame state, counters and shift register.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; everything holds unless sample_enable is high.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        good_stop_c = 1'b0;
        bad_stop_c  = 1'b0;

        if (sample_enable) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        tick_d  = '0;
                        state_d = START;
                    end
                end

                START: begin
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (tick_q == TICK_END) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (rx_s == STOP_LEVEL) begin
                            good_stop_c = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            bad_stop_c = 1'b1;
                            state_d    = WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Holding register: a new byte lands only if the slot is empty or being accepted now.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= bad_stop_c;
            overrun       <= good_stop_c && valid && !ready;
            if (good_stop_c && (!valid || ready)) begin
                data  <= shift_q;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized traffic
// checked against a transaction-level byte/event model.
module tb_uart_receiver;

    localparam int unsigned OS = 8;

    logic       CLKIN;
    logic       RESET;
    logic       sample_enable;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    int se_period = 1;
    int se_cnt    = 0;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes that must be handed over, and expected event counts.
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         rd_idx = 0;

    // Observations gathered by the monitor.
    logic [7:0] got_q[$];
    int         got_fe     = 0;
    int         got_ov     = 0;
    int         valid_hi   = 0;
    int         pulse_viol = 0;
    int         stab_viol  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic       prev_fe    = 1'b0;
    logic       prev_ov    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .CLKIN         (CLKIN),
        .RESET         (RESET),
        .sample_enable (sample_enable),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    always @(posedge CLKIN) se_cnt <= (se_cnt + 1 >= se_period) ? 0 : se_cnt + 1;
    assign sample_enable = (se_cnt == 0);

    always @(negedge CLKIN) begin
        if (RESET) begin
            prev_valid <= 1'b0;
            prev_acc   <= 1'b0;
            prev_fe    <= 1'b0;
            prev_ov    <= 1'b0;
        end else begin
            if (valid && ready) got_q.push_back(data);
            valid_hi   <= valid_hi + int'(valid);
            got_fe     <= got_fe + int'(framing_error);
            got_ov     <= got_ov + int'(overrun);
            pulse_viol <= pulse_viol + int'(framing_error && prev_fe) + int'(overrun && prev_ov);
            stab_viol  <= stab_viol + int'(valid && prev_valid && !prev_acc && (data !== prev_data));
            prev_valid <= valid;
            prev_acc   <= valid && ready;
            prev_fe    <= framing_error;
            prev_ov    <= overrun;
            prev_data  <= data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Compare newly delivered bytes and cumulative event counts against the model.
    task automatic check_model(input string tag);
        check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = rd_idx; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        rd_idx = exp_q.size();
        check_eq({tag, "_fe"}, 32'(got_fe), 32'(exp_fe));
        check_eq({tag, "_ov"}, 32'(got_ov), 32'(exp_ov));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLKIN);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cyc(OS * se_period);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        if (n > 0) wait_cyc(n * OS * se_period);
    endtask

    // Bad stop bits keep the line low for a second bit period before releasing it.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) send_bit(1'b0);
        rx = 1'b1;
    endtask

    task automatic false_start(input int ticks);
        rx = 1'b0;
        wait_cyc(ticks * se_period);
        rx = 1'b1;
    endtask

    initial begin
        int v0;
        logic [7:0] b;
        logic       stop;

        rx    = 1'b1;
        ready = 1'b1;
        RESET = 1'b1;
        wait_cyc(3);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_fe", 32'(framing_error), 32'd0);
        check_eq("rst_ov", 32'(overrun), 32'd0);
        RESET = 1'b0;
        idle_bits(2);

        // Single good frame: one valid cycle, no error pulses.
        v0 = valid_hi;
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        idle_bits(1);
        check_model("a5");
        check_eq("a5_valid_cycles", 32'(valid_hi - v0), 32'd1);

        // Two-tick glitch is rejected, the following frame is received.
        false_start(2);
        idle_bits(2);
        check_model("glitch");
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        idle_bits(1);
        check_model("3c");

        // Low stop bit: framing error, no byte, recovery on the next frame.
        send_frame(8'h81, 1'b0);
        exp_fe++;
        idle_bits(2);
        check_model("ferr");
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        idle_bits(1);
        check_model("55");

        // Consumer stalled: second byte dropped with an overrun, first byte kept.
        ready = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        exp_ov++;
        idle_bits(1);
        check_eq("ovr_valid", 32'(valid), 32'd1);
        check_eq("ovr_data", 32'(data), 32'h12);
        check_eq("ovr_count", 32'(got_ov), 32'(exp_ov));
        ready = 1'b1;
        exp_q.push_back(8'h12);
        wait_cyc(1);
        check_eq("ovr_clear", 32'(valid), 32'd0);
        idle_bits(1);
        check_model("ovr");

        // Reset in the middle of bit 4 of 0xFF clears outputs without a clock edge.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_cyc(OS / 2);
        @(negedge CLKIN);
        #2;
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_data", 32'(data), 32'd0);
        check_eq("mid_rst_fe", 32'(framing_error), 32'd0);
        check_eq("mid_rst_ov", 32'(overrun), 32'd0);
        wait_cyc(2);
        RESET = 1'b0;
        idle_bits(2);
        check_model("mid_rst");
        send_frame(8'h0F, 1'b1);
        exp_q.push_back(8'h0F);
        idle_bits(1);
        check_model("0f");

        // Sparse sample_enable with back-to-back frames.
        se_period = 3;
        v0 = valid_hi;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        idle_bits(1);
        check_model("se3");
        check_eq("se3_valid_cycles", 32'(valid_hi - v0), 32'd2);

        // Randomized traffic: bytes, stop errors, glitches, strobe rates and gaps.
        for (int n = 0; n < 40; n++) begin
            se_period = int'($urandom_range(1, 3));
            idle_bits(1);
            if ($urandom_range(0, 7) == 0) begin
                false_start(int'($urandom_range(1, 2)));
                idle_bits(1);
            end
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop);
            if (stop) exp_q.push_back(b);
            else      exp_fe++;
            idle_bits(stop ? int'($urandom_range(0, 2)) : 1);
        end
        idle_bits(2);
        check_model("rand");

        check_eq("pulse_width", 32'(pulse_viol), 32'd0);
        check_eq("data_stable", 32'(stab_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
